// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: drives a variable-latency req/ready data bus, builds store
// lanes, aligns/extends load data and stalls the pipeline while an access is outstanding.
module memory_access_unit #(
    parameter int         TIMEOUT_CYCLES = 256,
    parameter logic [1:0] LOAD_SRC       = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  AddressingControlM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AccessFaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic        is_store;
    logic        is_load;
    logic        access;
    logic        bad_funct3;
    logic        misaligned;
    logic        fault_check;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // A store takes priority when the EX/MEM register marks both a store and a load.
    assign is_store = MemWriteM;
    assign is_load  = !MemWriteM && (ResultSrcM == LOAD_SRC);
    assign access   = is_store || is_load;

    always_comb begin
        bad_funct3 = 1'b0;
        misaligned = 1'b0;
        case (AddressingControlM)
            3'b000: ;
            3'b001: misaligned = ALUResultM[0];
            3'b010: misaligned = |ALUResultM[1:0];
            3'b100: bad_funct3 = is_store;
            3'b101: begin
                bad_funct3 = is_store;
                misaligned = ALUResultM[0];
            end
            default: bad_funct3 = 1'b1;
        endcase
    end

    assign fault_check = access && (bad_funct3 || misaligned);

    always_comb begin
        store_be   = 4'b0000;
        store_data = WriteDataM;
        case (AddressingControlM)
            3'b000: begin
                store_data = {4{WriteDataM[7:0]}};
                store_be   = 4'b0001 << ALUResultM[1:0];
            end
            3'b001: begin
                store_data = {2{WriteDataM[15:0]}};
                store_be   = 4'b0011 << {ALUResultM[1], 1'b0};
            end
            3'b010: store_be = 4'b1111;
            default: ;
        endcase
    end

    assign shifted = mem_rdata >> {ALUResultM[1:0], 3'b000};

    always_comb begin
        case (AddressingControlM)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign mem_addr  = {ALUResultM[31:2], 2'b00};
    assign mem_wdata = store_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // WAIT relies on upstream being frozen, so it only watches ready and the timeout counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (access && !fault_check && !mem_ready) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end
            end
            S_WAIT: begin
                if (mem_ready || (cnt == CNT_LAST)) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        StallM       = 1'b0;
        AccessFaultM = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        ReadDataM    = 32'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        if (fault_check) begin
                            AccessFaultM = 1'b1;
                        end else begin
                            mem_req = 1'b1;
                            StallM  = !mem_ready;
                        end
                    end
                end
                S_WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        StallM = 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        AccessFaultM = 1'b1;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                default: ;
            endcase
            mem_we = mem_req && is_store;
            if (mem_req && is_store) begin
                mem_be = store_be;
            end
            // A timed-out load never sees ready, so its result stays zero.
            if (mem_req && is_load && mem_ready) begin
                ReadDataM = load_data;
            end
        end
    end

endmodule
